// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width and FSM state encoding.
package nibble_serial_subtractor_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_sub_slice.sv
// Combinational 4-bit slice computing x + ~y + cin with carry lookahead.
module nibble_sub_slice
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] d,
  output logic               cout
);

  logic [SLICE_W-1:0] yn;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign yn = ~y;
  assign g  = x & yn;
  assign p  = x ^ yn;

  // Every carry is derived from generate/propagate terms and cin, not rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign d    = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial a - b, one nibble per cycle through a single shared slice, with valid/ready handshakes.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSlices = WIDTH / SLICE_W;
  localparam int unsigned IdxW    = $clog2(NSlices);
  localparam int unsigned LastIdx = NSlices - 1;

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_d;
  logic               borrow_q, ovf_q, zero_q, in_ready_q, out_valid_q;
  logic [SLICE_W-1:0] slice_x, slice_y, slice_d;
  logic               slice_cout;
  logic               last_slice;

  assign slice_x    = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_y    = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last_slice = (idx_q == IdxW'(LastIdx));

  nibble_sub_slice u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_q),
    .d    (slice_d),
    .cout (slice_cout)
  );

  always_comb begin
    diff_d = diff_q;
    diff_d[idx_q*SLICE_W +: SLICE_W] = slice_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= '0;
            carry_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          diff_q  <= diff_d;
          carry_q <= slice_cout;
          if (last_slice) begin
            // Flags use the just-computed top nibble, since diff_q is not yet updated.
            borrow_q    <= ~slice_cout;
            ovf_q       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (slice_d[SLICE_W-1] ^ a_q[WIDTH-1]);
            zero_q      <= (diff_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit; operands a/b are valid.
REQ-005 SHALL have port in_ready, output, 1 bit; the block accepts operands.
REQ-006 SHALL have port a, input, WIDTH bits, the minuend.
REQ-007 SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-008 SHALL have port out_valid, output, 1 bit; the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit; the consumer accepts the result.
REQ-010 SHALL have port diff, output, WIDTH bits, a - b modulo 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1 bit; set when unsigned a < b.
REQ-012 SHALL have port ovf, output, 1 bit; signed two's-complement overflow.
REQ-013 SHALL have port zero, output, 1 bit; set when diff == 0.

Function
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-016 In IDLE, when in_valid && in_ready, SHALL register a and b, clear the slice index, set the carry register to 1 (two's-complement subtract), and go to RUN.
REQ-017 In RUN, each cycle SHALL compute slice idx = a[4*idx+3:4*idx] + ~b[4*idx+3:4*idx] + carry, write the 4-bit sum into diff[4*idx+3:4*idx], register carry-out, and increment idx.
REQ-018 SHALL leave RUN for DONE on the edge that processes slice WIDTH/4-1; no wrap of idx inside RUN.
REQ-019 Latency SHALL be exactly WIDTH/4 rising edges from the accepting edge until out_valid is high (4 for WIDTH=16); acceptance happens on the same edge that in_valid&&in_ready is sampled high.
REQ-020 On entering DONE, SHALL set borrow = ~final carry, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), and zero = (diff == 0).
REQ-021 In DONE, diff, borrow, ovf and zero SHALL hold stable until out_valid && out_ready; out_valid SHALL NOT drop before that handshake.
REQ-022 On the out_valid && out_ready edge, SHALL return to IDLE; in_ready is high the next cycle (one idle bubble between jobs, no overlap).
REQ-023 in_valid SHALL be ignored in RUN and DONE; changes to a/b after acceptance SHALL NOT affect the result.
REQ-024 diff bits of slices not yet processed SHALL NOT be observed by the consumer; they may hold stale values during RUN.

Reset
REQ-025 While rst = 1 at a rising edge, SHALL go to IDLE and clear idx, carry, diff, borrow, ovf and zero to 0; out_valid = 0 and in_ready = 1 after that edge.
REQ-026 Reset in RUN or DONE SHALL abort the job, discard the partial result, and generate no out_valid for it.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2) and SLICE_W = 4 in the shared package/include used by the arithmetic blocks.
REQ-029 SHALL instantiate one combinational sub-module, nibble_sub_slice: inputs x[3:0], y[3:0], cin; outputs d[3:0], cout; computing x + ~y + cin with internal lookahead carries.
REQ-030 SHALL use a single instance of nibble_sub_slice, time-multiplexed by idx, and SHALL NOT instantiate WIDTH/4 copies.

Verification
REQ-031 SHALL test a=0x1234, b=0x0234, out_ready=1 -> after 4 edges, out_valid=1 with diff=0x1000, borrow=0, ovf=0, zero=0.
REQ-032 SHALL test a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0, zero=0.
REQ-033 SHALL test a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; and a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
REQ-034 SHALL test a=b=0xA5A5 with out_ready held low for 3 cycles -> diff=0x0000, zero=1, and outputs stable for all 3 stall cycles; IDLE follows the handshake.
REQ-035 SHALL test rst for one cycle during the 2nd RUN cycle -> no out_valid; the next job a=0x0010, b=0x0001 gives diff=0x000F with correct latency.
REQ-036 SHALL run 10k random a/b with random out_ready and in_valid -> match a scoreboard of (a-b) mod 2^16, borrow and ovf, with no lost or duplicated results.
